// File: rtl/int_kernel_multiplier_if.sv
// Bus bundle for the kernel multiplier: weight load channel, reload request,
// pixel window input channel, product vector output channel, and status.
interface int_kernel_multiplier_if #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_INPUTS = 9
);

  logic                               w_valid;
  logic [DATA_WIDTH-1:0]              w_data;
  logic                               w_ready;
  logic                               reload;
  logic                               in_valid;
  logic [NUM_INPUTS*DATA_WIDTH-1:0]   in_data;
  logic                               in_ready;
  logic                               out_valid;
  logic [NUM_INPUTS*2*DATA_WIDTH-1:0] out_data;
  logic                               out_ready;
  logic                               weights_loaded;

  // Producer/consumer side that talks to the multiplier
  modport master (
    output w_valid, w_data, reload, in_valid, in_data, out_ready,
    input  w_ready, in_ready, out_valid, out_data, weights_loaded
  );

  // The multiplier itself
  modport slave (
    input  w_valid, w_data, reload, in_valid, in_data, out_ready,
    output w_ready, in_ready, out_valid, out_data, weights_loaded
  );

endinterface

// File: rtl/int_kernel_multiplier.sv
// Per-lane unsigned multiplier for a convolution kernel. A kernel of
// NUM_INPUTS weights is loaded word by word, then pixel windows stream
// through a two-stage pipeline producing full-width lane products that feed
// a downstream adder tree. A reload request drains the pipeline with the old
// kernel before a new one is accepted.
module int_kernel_multiplier #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_INPUTS = 9
) (
  input logic                  clk,
  input logic                  rst,
  int_kernel_multiplier_if.slave bus
);

  localparam int PROD_WIDTH = 2 * DATA_WIDTH;
  localparam int WIN_WIDTH  = NUM_INPUTS * DATA_WIDTH;
  localparam int OUT_WIDTH  = NUM_INPUTS * PROD_WIDTH;
  localparam int IDX_WIDTH  = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_INPUTS - 1);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                 state;
  state_t                 state_next;
  logic [IDX_WIDTH-1:0]   idx;
  logic [IDX_WIDTH-1:0]   idx_next;

  logic [DATA_WIDTH-1:0]  weight [NUM_INPUTS];

  logic                   w_ready;
  logic                   in_ready;
  logic                   w_fire;
  logic                   in_fire;
  logic                   en;

  logic                   s1_valid;
  logic [WIN_WIDTH-1:0]   s1_data;
  logic                   s2_valid;
  logic [OUT_WIDTH-1:0]   s2_data;
  logic [OUT_WIDTH-1:0]   products;

  // The whole pipeline advances together unless a finished vector is waiting
  // on the consumer; that keeps output data frozen during a stall.
  assign en      = !s2_valid || bus.out_ready;
  assign w_fire  = bus.w_valid && w_ready;
  assign in_fire = bus.in_valid && in_ready;

  assign bus.w_ready        = w_ready;
  assign bus.in_ready       = in_ready;
  assign bus.out_valid      = s2_valid;
  assign bus.out_data       = s2_data;
  assign bus.weights_loaded = (state == RUN);

  // State and load-index registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= LOAD;
      idx   <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
    end
  end

  // Next-state, load index and handshake readies
  always_comb begin
    state_next = state;
    idx_next   = idx;
    w_ready    = 1'b0;
    in_ready   = 1'b0;
    case (state)
      LOAD: begin
        w_ready = 1'b1;
        if (bus.w_valid) begin
          if (idx == LAST_IDX) begin
            state_next = RUN;
            idx_next   = '0;
          end else begin
            idx_next = idx + 1'b1;
          end
        end
      end
      RUN: begin
        in_ready = en;
        if (bus.reload) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (!s1_valid && !s2_valid) begin
          state_next = LOAD;
          idx_next   = '0;
        end
      end
      default: begin
        state_next = LOAD;
        idx_next   = '0;
      end
    endcase
  end

  // Kernel storage; only written while loading, so in-flight windows always
  // see the kernel that was current when they were accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_INPUTS; i++) begin
        weight[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_INPUTS; i++) begin
        if (w_fire && (idx == IDX_WIDTH'(i))) begin
          weight[i] <= bus.w_data;
        end
      end
    end
  end

  // Stage 1: capture the accepted window
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else if (en) begin
      s1_valid <= in_fire;
      if (in_fire) begin
        s1_data <= bus.in_data;
      end
    end
  end

  // Full-width unsigned lane products of the stage-1 window
  always_comb begin
    products = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      products[i*PROD_WIDTH +: PROD_WIDTH] =
        PROD_WIDTH'(weight[i]) * PROD_WIDTH'(s1_data[i*DATA_WIDTH +: DATA_WIDTH]);
    end
  end

  // Stage 2: register products; data only changes when a new vector arrives
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_data  <= '0;
    end else if (en) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_data <= products;
      end
    end
  end

endmodule

// File: tb/tb_int_kernel_multiplier.sv
// Self-checking bench for int_kernel_multiplier: a table of lane corner
// cases, directed reload/stall/reset sequences, and a randomized soak, all
// checked against a transaction-level model (kernel array + queue of
// pending product vectors).
module tb_int_kernel_multiplier;

  localparam int DW   = 16;
  localparam int NI   = 9;
  localparam int PW   = 2 * DW;
  localparam int WINW = NI * DW;
  localparam int OUTW = NI * PW;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // Free-running clock
  always #5 clk = ~clk;

  int_kernel_multiplier_if #(.DATA_WIDTH(DW), .NUM_INPUTS(NI)) bus ();

  int_kernel_multiplier #(.DATA_WIDTH(DW), .NUM_INPUTS(NI)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef enum {M_LOAD, M_RUN, M_DRAIN} mstate_t;

  typedef struct {
    logic [OUTW-1:0] data;
    int              acceptCycle;
  } pend_t;

  typedef struct {
    logic [DW-1:0] weight;
    logic [DW-1:0] lane;
    logic [PW-1:0] expected;
  } vec_t;

  pend_t           pending[$];
  logic [DW-1:0]   kernel [NI];
  mstate_t         mstate;
  int              wordCount;
  int              cycle;
  int              popCount;
  int              lastAcceptCycle;
  bit              lastAccepted;
  logic [OUTW-1:0] lastOut;
  vec_t            vecs [NI];

  int errors = 0;
  int checks = 0;

  // Hard stop in case something hangs
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [OUTW-1:0] act, input logic [OUTW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic timeoutFail(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: bound expired", name);
  endtask

  function automatic logic [OUTW-1:0] kernelTimes(input logic [WINW-1:0] win);
    logic [OUTW-1:0] r;
    longint unsigned p;
    r = '0;
    for (int i = 0; i < NI; i++) begin
      p = longint'(kernel[i]) * longint'(win[i*DW +: DW]);
      r[i*PW +: PW] = PW'(p);
    end
    return r;
  endfunction

  function automatic bit expValid();
    return (pending.size() > 0) && (pending[0].acceptCycle + 2 <= cycle);
  endfunction

  function automatic logic [WINW-1:0] randWindow();
    logic [WINW-1:0] w;
    for (int i = 0; i < NI; i++) w[i*DW +: DW] = DW'($urandom);
    return w;
  endfunction

  task automatic modelReset();
    mstate    = M_LOAD;
    wordCount = 0;
    for (int i = 0; i < NI; i++) kernel[i] = '0;
    pending.delete();
    lastOut = '0;
  endtask

  // One clock cycle: called at a negedge with inputs already driven
  task automatic applyStimulus();
    bit v;
    bit inRdy;
    bit pipeEmpty;
    #1;
    v     = expValid();
    inRdy = (mstate == M_RUN) && (!v || bus.out_ready);
    checkOutput("w_ready", OUTW'(bus.w_ready), OUTW'(mstate == M_LOAD));
    checkOutput("weights_loaded", OUTW'(bus.weights_loaded), OUTW'(mstate == M_RUN));
    checkOutput("in_ready", OUTW'(bus.in_ready), OUTW'(inRdy));
    checkOutput("out_valid", OUTW'(bus.out_valid), OUTW'(v));
    if (v) checkOutput("out_data", bus.out_data, pending[0].data);
    else   checkOutput("out_data_hold", bus.out_data, lastOut);

    pipeEmpty    = (pending.size() == 0);
    lastAccepted = 1'b0;
    if (v && bus.out_ready) begin
      lastOut = pending[0].data;
      void'(pending.pop_front());
      popCount++;
    end
    case (mstate)
      M_LOAD: begin
        if (bus.w_valid) begin
          kernel[wordCount] = bus.w_data;
          wordCount++;
          if (wordCount == NI) begin
            mstate    = M_RUN;
            wordCount = 0;
          end
        end
      end
      M_RUN: begin
        if (bus.in_valid && inRdy) begin
          pending.push_back('{kernelTimes(bus.in_data), cycle});
          lastAccepted    = 1'b1;
          lastAcceptCycle = cycle;
        end
        if (bus.reload) mstate = M_DRAIN;
      end
      default: begin
        if (pipeEmpty) mstate = M_LOAD;
      end
    endcase
    cycle++;
    @(negedge clk);
  endtask

  task automatic quietInputs();
    bus.w_valid  = 1'b0;
    bus.w_data   = '0;
    bus.reload   = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
  endtask

  task automatic doReset();
    rst = 1'b1;
    quietInputs();
    #1;
    checkOutput("rst_out_valid", OUTW'(bus.out_valid), '0);
    checkOutput("rst_out_data", bus.out_data, '0);
    checkOutput("rst_in_ready", OUTW'(bus.in_ready), '0);
    checkOutput("rst_weights_loaded", OUTW'(bus.weights_loaded), '0);
    modelReset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic idle(input int n);
    quietInputs();
    for (int i = 0; i < n; i++) applyStimulus();
  endtask

  task automatic gotoLoad();
    int guard;
    guard = 0;
    quietInputs();
    if (mstate == M_RUN) begin
      bus.reload = 1'b1;
      applyStimulus();
      bus.reload = 1'b0;
    end
    while (mstate != M_LOAD && guard < 200) begin
      applyStimulus();
      guard++;
    end
    if (mstate != M_LOAD) timeoutFail("drain_timeout");
  endtask

  task automatic loadKernel(input logic [WINW-1:0] k);
    gotoLoad();
    for (int i = 0; i < NI; i++) begin
      bus.w_valid = 1'b1;
      bus.w_data  = k[i*DW +: DW];
      applyStimulus();
    end
    bus.w_valid = 1'b0;
  endtask

  task automatic sendWindow(input logic [WINW-1:0] win);
    int guard;
    guard        = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = win;
    do begin
      applyStimulus();
      guard++;
    end while (!lastAccepted && guard < 200);
    if (!lastAccepted) timeoutFail("accept_timeout");
    bus.in_valid = 1'b0;
  endtask

  // Main test sequence
  initial begin
    logic [WINW-1:0] k;
    logic [WINW-1:0] win;
    logic [OUTW-1:0] ramp;
    logic [WINW-1:0] sw [4];
    int n;
    int cyc;
    int popStart;

    vecs[0] = '{16'hFFFF, 16'hFFFF, 32'hFFFE0001};
    vecs[1] = '{16'h0000, 16'hFFFF, 32'h00000000};
    vecs[2] = '{16'h0001, 16'hFFFF, 32'h0000FFFF};
    vecs[3] = '{16'h8000, 16'h0002, 32'h00010000};
    vecs[4] = '{16'hFFFF, 16'h0001, 32'h0000FFFF};
    vecs[5] = '{16'h1234, 16'h0010, 32'h00012340};
    vecs[6] = '{16'h0100, 16'h0100, 32'h00010000};
    vecs[7] = '{16'h0007, 16'h0009, 32'h0000003F};
    vecs[8] = '{16'h00FF, 16'h00FF, 32'h0000FE01};

    cycle    = 0;
    popCount = 0;
    lastAcceptCycle = 0;
    lastAccepted    = 1'b0;
    modelReset();
    quietInputs();
    bus.out_ready = 1'b1;

    @(negedge clk);
    doReset();
    idle(2);

    // Kernel 1..9, window of 2s: products 2,4,..,18 two cycles after accept
    for (int i = 0; i < NI; i++) begin
      k[i*DW +: DW]   = DW'(i + 1);
      win[i*DW +: DW] = DW'(2);
      ramp[i*PW +: PW] = PW'(2 * (i + 1));
    end
    loadKernel(k);
    sendWindow(win);
    #1;
    checkOutput("latency_early", OUTW'(bus.out_valid), '0);
    applyStimulus();
    #1;
    checkOutput("latency_valid", OUTW'(bus.out_valid), OUTW'(1));
    checkOutput("ramp_data", bus.out_data, ramp);
    idle(2);

    // Lane corner-case table, including full-range 0xFFFF * 0xFFFF
    for (int i = 0; i < NI; i++) begin
      k[i*DW +: DW]   = vecs[i].weight;
      win[i*DW +: DW] = vecs[i].lane;
    end
    loadKernel(k);
    sendWindow(win);
    applyStimulus();
    #1;
    for (int i = 0; i < NI; i++) begin
      checkOutput($sformatf("vec%0d", i), OUTW'(bus.out_data[i*PW +: PW]), OUTW'(vecs[i].expected));
    end
    idle(2);

    // Four back-to-back windows with a three-cycle consumer stall
    for (int i = 0; i < 4; i++) sw[i] = randWindow();
    n        = 0;
    cyc      = 0;
    popStart = popCount;
    while ((n < 4 || pending.size() > 0) && cyc < 100) begin
      bus.out_ready = !(cyc >= 3 && cyc < 6);
      bus.in_valid  = (n < 4);
      if (n < 4) bus.in_data = sw[n];
      applyStimulus();
      if (lastAccepted) n++;
      cyc++;
    end
    bus.out_ready = 1'b1;
    if (cyc >= 100) timeoutFail("stream_timeout");
    checkOutput("stream_count", OUTW'(popCount - popStart), OUTW'(4));
    idle(2);

    // Reload with two windows in flight: both finish with the old kernel
    sendWindow(randWindow());
    sendWindow(randWindow());
    bus.reload = 1'b1;
    applyStimulus();
    bus.reload = 1'b0;
    #1;
    checkOutput("drain_w_ready", OUTW'(bus.w_ready), '0);
    for (int i = 0; i < NI; i++) k[i*DW +: DW] = DW'($urandom);
    loadKernel(k);
    sendWindow(randWindow());
    idle(3);

    // Window accepted in the same cycle as reload still completes
    bus.in_valid = 1'b1;
    bus.in_data  = randWindow();
    bus.reload   = 1'b1;
    applyStimulus();
    checkOutput("reload_accept", OUTW'(lastAccepted), OUTW'(1));
    idle(4);

    // Reset part-way through a kernel load
    gotoLoad();
    for (int i = 0; i < 5; i++) begin
      bus.w_valid = 1'b1;
      bus.w_data  = DW'($urandom);
      applyStimulus();
    end
    doReset();
    for (int i = 0; i < 8; i++) begin
      bus.w_valid = 1'b1;
      bus.w_data  = DW'(i + 3);
      applyStimulus();
    end
    bus.in_valid = 1'b1;
    bus.in_data  = randWindow();
    #1;
    checkOutput("partial_in_ready", OUTW'(bus.in_ready), '0);
    bus.w_data = DW'(11);
    applyStimulus();
    quietInputs();
    #1;
    checkOutput("reloaded_weights_loaded", OUTW'(bus.weights_loaded), OUTW'(1));
    sendWindow(randWindow());
    idle(3);

    // Reset while a vector is stalled at the output
    bus.out_ready = 1'b0;
    sendWindow(randWindow());
    idle(2);
    #1;
    checkOutput("stalled_valid", OUTW'(bus.out_valid), OUTW'(1));
    doReset();
    bus.out_ready = 1'b1;
    idle(4);
    for (int i = 0; i < NI; i++) k[i*DW +: DW] = DW'($urandom);
    loadKernel(k);
    sendWindow(randWindow());
    idle(3);

    // Randomized soak against the model
    for (int c = 0; c < 800; c++) begin
      if (c == 400) doReset();
      bus.in_valid  = ($urandom_range(3) != 0);
      bus.in_data   = ($urandom_range(15) == 0) ? {WINW{1'b1}} : randWindow();
      bus.out_ready = ($urandom_range(2) != 0);
      bus.reload    = ($urandom_range(50) == 0);
      bus.w_valid   = ($urandom_range(1) == 1);
      bus.w_data    = ($urandom_range(7) == 0) ? 16'hFFFF : DW'($urandom);
      applyStimulus();
    end
    bus.out_ready = 1'b1;
    idle(10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
